pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//  Parametrised N-channel PWM generator. One prescaler and one shared period counter feed
//  per-channel comparators. Duty registers are double-buffered so updates are glitch-free.
//  Drives motor/LED loads from the lab control datapath; replaces single-channel fixed-8-bit PWM.
// PARAMETERS
//  CH        4   number of output channels (>=1)
//  WIDTH     8   duty/counter width in bits (2..16); MAX = 2**WIDTH-1
//  PRESCALE  19  clk cycles per counter tick (>=1; 1 = tick every clk)
// PORTS
//  clk           in   1         system clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  en            in   1         run enable; 0 = counters held, outputs low
//  duty          in   CH*WIDTH  channel k duty at [k*WIDTH +: WIDTH]
//  pwm_out       out  CH        registered PWM outputs
//  period_pulse  out  1         only with PWM_PERIOD_PULSE_EN; 1-clk pulse at period start
// BEHAVIOUR
//  - One clock; reset asynchronous, active-low. On rst_n=0: pwm_out=0, prescaler=0,
//    cnt=0, all shadow duties=0, period_pulse=0.
//  - Prescaler counts 0..PRESCALE-1 while en=1; tick asserted in the cycle it equals
//    PRESCALE-1, then wraps to 0. PRESCALE=1: tick every cycle.
//  - Period counter cnt (WIDTH bits) advances on tick: 0..MAX-1, wraps MAX-1 -> 0.
//    Period = MAX*PRESCALE clk (8-bit, 19: 255*19 = 4845).
//  - Shadow load: on the tick that wraps cnt to 0, shadow[k] <= duty[k] for all k
//    simultaneously. Mid-period duty changes have no effect until the next wrap.
//  - Compare, registered every clk: pwm_out[k] <= en & ((shadow[k]==MAX) | (cnt < shadow[k])).
//    duty=0 -> constant 0; duty=MAX -> constant 1; otherwise high for shadow*PRESCALE clk/period.
//    pwm_out lags the cnt/shadow state by exactly 1 clk.
//  - en=0: prescaler and cnt forced to 0; shadow[k] <= duty[k] every clk; pwm_out <= 0 next clk.
//    en 0->1: the first period starts at cnt=0 with the current duty; no partial period.
//  - Reset mid-period: immediate return to reset state; no output glitch beyond async clear.
//  - Width rules: compare unsigned; prescaler width = max(1,$clog2(PRESCALE)); no overflow possible.
// CONFIGURATION
//  PWM_PERIOD_PULSE_EN defined: port period_pulse exists; registered, high 1 clk,
//    aligned with the first pwm_out cycle of each new period (incl. first after en rise).
//  Undefined: port and its logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pwm_pkg: WIDTH/PRESCALE defaults, MAX helper function,
//    prescaler-width helper (clog2 with min 1).
//  - Sub-module pwm_prescaler (clk, rst_n, en -> tick), reused by future timer blocks.
//  - Channels generated via generate-for; no per-channel counters.
// TESTING (CH=4, WIDTH=8, PRESCALE=4 unless noted; period 1020 clk)
//  1 Reset: rst_n low mid-run -> pwm_out=0 same cycle; after release with en=0, stays 0.
//  2 Boundaries: duty={255,0,128,1} -> ch0 constant 1, ch1 constant 0, ch2 512 clk high/1020,
//    ch3 4 clk high/1020; measure 3 consecutive periods.
//  3 Shadowing: ch0 64 -> 200 at cnt=100 -> current period still 256 clk high, next 800.
//  4 Enable: drop en at cnt=50 -> pwm_out 0 next clk; re-raise -> high run starts 1 clk later,
//    full-length first period.
//  5 PRESCALE=1, duty=3 -> 3 clk high every 255 clk; PRESCALE=19, duty=1 -> 19 clk high/4845.
//  6 With PWM_PERIOD_PULSE_EN: period_pulse exactly 1 clk every 1020 clk, coincident with
//    rising pwm_out of duty=128 channel; never asserts while en=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM family: default sizing and the small
// elaboration-time helpers used to size counters.
package pwm_pkg;

    localparam int CH_DEFAULT       = 4;
    localparam int WIDTH_DEFAULT    = 8;
    localparam int PRESCALE_DEFAULT = 19;

    // Largest duty / counter code for a given width (2**w - 1).
    function automatic int unsigned pwm_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Bits needed to hold 0..p-1, never less than one bit.
    function automatic int unsigned presc_width(input int unsigned p);
        if (p <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(p);
        end
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock prescaler: emits a one-clock tick every PRESCALE
// enabled cycles. Held at zero while disabled so a restart is aligned.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned     PW     = presc_width(PRESCALE);
    localparam logic [PW-1:0]   LAST_V = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r;
    logic          at_last_s;

    assign at_last_s = (presc_r == LAST_V);

    // Count 0..PRESCALE-1 while enabled, forced to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
        end else if (!en) begin
            presc_r <= {PW{1'b0}};
        end else if (at_last_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // The tick is a decode of the registered count, so it is glitch-free
    // within the cycle and lines up with the count reaching PRESCALE-1.
    assign tick = en & at_last_s;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator: one prescaler, one shared period counter and a
// double-buffered duty register plus comparator per channel.
// Optional feature macro: PWM_PERIOD_PULSE_EN adds the period_pulse output.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH       = CH_DEFAULT,
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CH*WIDTH-1:0] duty,
    output logic [CH-1:0]     pwm_out
`ifdef PWM_PERIOD_PULSE_EN
    ,
    output logic              period_pulse
`endif
);

    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(pwm_max(WIDTH));
    localparam logic [WIDTH-1:0] LAST_CNT_V = WIDTH'(pwm_max(WIDTH) - 32'd1);

    logic             tick_s;
    logic [WIDTH-1:0] cnt_r;
    logic             wrap_s;
    logic [CH-1:0]    cmp_s;
    logic [CH-1:0]    pwm_out_r;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_s)
    );

    // A wrap is the tick that takes the counter from MAX-1 back to 0; it
    // is also the instant new duties are latched into the shadows.
    assign wrap_s = tick_s & (cnt_r == LAST_CNT_V);

    // Shared period counter, 0..MAX-1, parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (!en) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (wrap_s) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (tick_s) begin
            cnt_r <= cnt_r + WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [WIDTH-1:0] shadow_r;

        // Shadow tracks the live duty while idle so the first period after
        // enable uses it; while running it only changes at a wrap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_r <= {WIDTH{1'b0}};
            end else if (!en || wrap_s) begin
                shadow_r <= duty[k*WIDTH +: WIDTH];
            end else begin
                shadow_r <= shadow_r;
            end
        end

        // MAX is forced fully on, since cnt never reaches MAX.
        assign cmp_s[k] = en & ((shadow_r == MAX_V) | (cnt_r < shadow_r));
    end

    // Register all comparator results together so the outputs are clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out_r <= {CH{1'b0}};
        end else begin
            pwm_out_r <= cmp_s;
        end
    end

    assign pwm_out = pwm_out_r;

`ifdef PWM_PERIOD_PULSE_EN
    logic en_d_r;
    logic wrap_d_r;
    logic period_pulse_r;

    // Remember whether the previous cycle ended a period or was idle; the
    // cycle after either is the first cnt=0 cycle of a new period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d_r   <= 1'b0;
            wrap_d_r <= 1'b0;
        end else begin
            en_d_r   <= en;
            wrap_d_r <= wrap_s;
        end
    end

    // Registered alongside pwm_out so the pulse lands on the first output
    // cycle of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_pulse_r <= 1'b0;
        end else begin
            period_pulse_r <= en & (wrap_d_r | ~en_d_r);
        end
    end

    assign period_pulse = period_pulse_r;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: main instance at PRESCALE=4, plus
// PRESCALE=1 and PRESCALE=19 instances for the prescaler corner cases.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, en_c;
    logic [31:0] duty_a, duty_b, duty_c;
    logic [3:0]  pwm_a, pwm_b, pwm_c;
`ifdef PWM_PERIOD_PULSE_EN
    logic        pulse_a, pulse_b, pulse_c;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hi_cnt[4];
    logic first_val[4];

    always #5 clk = ~clk;

    pwm_multi #(.CH(4), .WIDTH(8), .PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en_a), .duty(duty_a), .pwm_out(pwm_a)
`ifdef PWM_PERIOD_PULSE_EN
        , .period_pulse(pulse_a)
`endif
    );

    pwm_multi #(.CH(4), .WIDTH(8), .PRESCALE(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .en(en_b), .duty(duty_b), .pwm_out(pwm_b)
`ifdef PWM_PERIOD_PULSE_EN
        , .period_pulse(pulse_b)
`endif
    );

    pwm_multi #(.CH(4), .WIDTH(8), .PRESCALE(19)) dut_p19 (
        .clk(clk), .rst_n(rst_n), .en(en_c), .duty(duty_c), .pwm_out(pwm_c)
`ifdef PWM_PERIOD_PULSE_EN
        , .period_pulse(pulse_c)
`endif
    );

    // Sample n cycles (1 time unit after each rising edge) of one instance,
    // counting high cycles per channel and noting the first sample.
    task automatic count_high(input int which, input int n);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            case (which)
                0:       s = pwm_a;
                1:       s = pwm_b;
                default: s = pwm_c;
            endcase
            for (int k = 0; k < 4; k++) begin
                if (s[k] === 1'b1) hi_cnt[k]++;
                if (i == 0) first_val[k] = s[k];
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en_a   = 1'b0; en_b = 1'b0; en_c = 1'b0;
        duty_a = {8'd0, 8'd0, 8'd0, 8'd255};
        duty_b = 32'd0; duty_c = 32'd0;
        repeat (3) @(posedge clk); #1;
        total_cnt++;
        if (pwm_a !== 4'b0000) $display("FAIL reset_state pwm_out=%b expected %b", pwm_a, 4'b0000);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        total_cnt++;
        if (pwm_a !== 4'b0000) $display("FAIL idle_after_reset pwm_out=%b expected %b", pwm_a, 4'b0000);
        else pass_cnt++;
        en_a = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (pwm_a !== 4'b0001) $display("FAIL run_before_reset pwm_out=%b expected %b", pwm_a, 4'b0001);
        else pass_cnt++;
        repeat (20) @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (pwm_a !== 4'b0000) $display("FAIL async_clear pwm_out=%b expected %b", pwm_a, 4'b0000);
        else pass_cnt++;
        @(posedge clk); #1;
        en_a  = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        total_cnt++;
        if (pwm_a !== 4'b0000) $display("FAIL idle_after_midrun_reset pwm_out=%b expected %b", pwm_a, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_boundaries();
        int exp_hi[4];
        exp_hi = '{1020, 0, 512, 4};
        en_a   = 1'b0;
        duty_a = {8'd1, 8'd128, 8'd0, 8'd255};
        @(posedge clk); #1;
        en_a = 1'b1;
        for (int p = 0; p < 3; p++) begin
            count_high(0, 1020);
            for (int k = 0; k < 4; k++) begin
                total_cnt++;
                if (hi_cnt[k] !== exp_hi[k])
                    $display("FAIL boundary_p%0d_ch%0d high=%0d expected %0d", p, k, hi_cnt[k], exp_hi[k]);
                else pass_cnt++;
            end
        end
        en_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_shadowing();
        int part;
        en_a   = 1'b0;
        duty_a = {8'd0, 8'd0, 8'd0, 8'd64};
        @(posedge clk); #1;
        en_a = 1'b1;
        count_high(0, 400);
        part = hi_cnt[0];
        duty_a = {8'd0, 8'd0, 8'd0, 8'd200};
        count_high(0, 620);
        part = part + hi_cnt[0];
        total_cnt++;
        if (part !== 256) $display("FAIL shadow_current_period high=%0d expected %0d", part, 256);
        else pass_cnt++;
        count_high(0, 1020);
        total_cnt++;
        if (hi_cnt[0] !== 800) $display("FAIL shadow_next_period high=%0d expected %0d", hi_cnt[0], 800);
        else pass_cnt++;
        en_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_enable();
        en_a   = 1'b0;
        duty_a = {8'd0, 8'd0, 8'd0, 8'd128};
        @(posedge clk); #1;
        en_a = 1'b1;
        count_high(0, 200);
        total_cnt++;
        if (pwm_a[0] !== 1'b1) $display("FAIL enable_running pwm_out0=%b expected %b", pwm_a[0], 1'b1);
        else pass_cnt++;
        en_a = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (pwm_a[0] !== 1'b0) $display("FAIL enable_drop pwm_out0=%b expected %b", pwm_a[0], 1'b0);
        else pass_cnt++;
        repeat (7) @(posedge clk); #1;
        en_a = 1'b1;
        total_cnt++;
        if (pwm_a[0] !== 1'b0) $display("FAIL enable_rise_same_cycle pwm_out0=%b expected %b", pwm_a[0], 1'b0);
        else pass_cnt++;
        count_high(0, 1020);
        total_cnt++;
        if (first_val[0] !== 1'b1) $display("FAIL enable_first_high pwm_out0=%b expected %b", first_val[0], 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (hi_cnt[0] !== 512) $display("FAIL enable_full_period high=%0d expected %0d", hi_cnt[0], 512);
        else pass_cnt++;
        count_high(0, 1);
        total_cnt++;
        if (first_val[0] !== 1'b1) $display("FAIL enable_next_period pwm_out0=%b expected %b", first_val[0], 1'b1);
        else pass_cnt++;
        en_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_prescale();
        duty_b = {8'd0, 8'd0, 8'd0, 8'd3};
        duty_c = {8'd0, 8'd0, 8'd0, 8'd1};
        @(posedge clk); #1;
        en_b = 1'b1;
        for (int p = 0; p < 2; p++) begin
            count_high(1, 255);
            total_cnt++;
            if (hi_cnt[0] !== 3 || first_val[0] !== 1'b1)
                $display("FAIL prescale1_p%0d high=%0d first=%b expected 3 and 1", p, hi_cnt[0], first_val[0]);
            else pass_cnt++;
        end
        en_b = 1'b0;
        en_c = 1'b1;
        count_high(2, 4845);
        total_cnt++;
        if (hi_cnt[0] !== 19 || first_val[0] !== 1'b1)
            $display("FAIL prescale19 high=%0d first=%b expected 19 and 1", hi_cnt[0], first_val[0]);
        else pass_cnt++;
        count_high(2, 1);
        total_cnt++;
        if (first_val[0] !== 1'b1) $display("FAIL prescale19_next_period pwm_out0=%b expected %b", first_val[0], 1'b1);
        else pass_cnt++;
        en_c = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef PWM_PERIOD_PULSE_EN
    task automatic test_period_pulse();
        int   pulses;
        int   coinc;
        int   pos[2];
        logic prev2;
        en_a   = 1'b0;
        duty_a = {8'd1, 8'd128, 8'd0, 8'd255};
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (pulse_a === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL pulse_while_idle count=%0d expected %0d", pulses, 0);
        else pass_cnt++;
        en_a   = 1'b1;
        pulses = 0;
        coinc  = 0;
        pos    = '{-1, -1};
        prev2  = 1'b0;
        for (int i = 0; i < 2040; i++) begin
            @(posedge clk); #1;
            if (pulse_a === 1'b1) begin
                if (pulses < 2) pos[pulses] = i;
                pulses++;
                if (pwm_a[2] === 1'b1 && prev2 === 1'b0) coinc++;
            end
            prev2 = pwm_a[2];
        end
        total_cnt++;
        if (pulses !== 2) $display("FAIL pulse_count count=%0d expected %0d", pulses, 2);
        else pass_cnt++;
        total_cnt++;
        if (coinc !== 2) $display("FAIL pulse_on_rise count=%0d expected %0d", coinc, 2);
        else pass_cnt++;
        total_cnt++;
        if (pos[0] !== 0 || pos[1] !== 1020)
            $display("FAIL pulse_spacing at=%0d,%0d expected 0,1020", pos[0], pos[1]);
        else pass_cnt++;
        en_a = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_boundaries();
        test_shadowing();
        test_enable();
        test_prescale();
`ifdef PWM_PERIOD_PULSE_EN
        test_period_pulse();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
